md5_search_controller: RTL and testbench

//  Parametrised brute-force candidate generator and digest checker for the MD5 cracker.

---
 rtl/md5_search_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_md5_search_controller.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/md5_search_controller.sv
// Brute-force plaintext odometer feeding a pipelined MD5 core, with an in-flight FIFO
// that pairs returned digests (strictly in issue order) with the plaintexts that made them.
// Latency: start in cycle N -> first candidate offered in N+1; match flagged the cycle after
// the matching digest. Backpressure: candidate held stable while cand_ready is low; issue stops
// while FIFO_DEPTH candidates are in flight.
// Ports: i_clk/i_reset_n (sync, active-low); i_start, i_stride, i_start_char, i_target_hash
// (sampled on accepted start); o_cand_valid/i_cand_ready/o_cand_data/o_cand_len (issue side);
// i_dig_valid/i_dig_data (digest return); o_busy, o_found, o_exhausted, o_found_plaintext,
// o_found_len, o_tried_count, o_proto_err (status).
module md5_search_controller #(
  parameter int         MAX_LEN    = 8,
  parameter logic [7:0] CHAR_MIN   = 8'h61,
  parameter logic [7:0] CHAR_MAX   = 8'h7A,
  parameter int         STRIDE_W   = 3,
  parameter int         FIFO_DEPTH = 16,
  localparam int        LEN_W      = $clog2(MAX_LEN + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_start,
  input  logic [STRIDE_W-1:0]    i_stride,
  input  logic [7:0]             i_start_char,
  input  logic [127:0]           i_target_hash,
  output logic                   o_cand_valid,
  input  logic                   i_cand_ready,
  output logic [8*MAX_LEN-1:0]   o_cand_data,
  output logic [LEN_W-1:0]       o_cand_len,
  input  logic                   i_dig_valid,
  input  logic [127:0]           i_dig_data,
  output logic                   o_busy,
  output logic                   o_found,
  output logic                   o_exhausted,
  output logic [8*MAX_LEN-1:0]   o_found_plaintext,
  output logic [LEN_W-1:0]       o_found_len,
  output logic [31:0]            o_tried_count,
  output logic                   o_proto_err
);

  localparam int         AW    = $clog2(FIFO_DEPTH);
  localparam logic [8:0] RADIX = {1'b0, CHAR_MAX} - {1'b0, CHAR_MIN} + 9'd1;

  typedef struct packed {
    logic [8*MAX_LEN-1:0] dat;
    logic [LEN_W-1:0]     len;
  } cand_t;

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FOUND, S_EXH} state_t;

  state_t               r_state;
  state_t               w_next_state;

  logic [7:0]           r_chars [MAX_LEN];
  logic [7:0]           w_nxt_chars [MAX_LEN];
  logic [LEN_W-1:0]     r_len;
  logic [LEN_W-1:0]     w_nxt_len;
  logic                 w_ovf;
  logic [STRIDE_W-1:0]  r_stride;
  logic [127:0]         r_target;

  cand_t                r_fifo [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [AW:0]          r_count;
  logic [AW:0]          w_count_nxt;
  cand_t                w_head;

  logic                 r_found;
  logic                 r_exhausted;
  logic [8*MAX_LEN-1:0] r_found_pt;
  logic [LEN_W-1:0]     r_found_len;
  logic [31:0]          r_tried;
  logic                 r_proto_err;

  logic                 w_active;
  logic                 w_start_ok;
  logic                 w_cand_valid;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_match;
  logic                 w_proto;
  logic [8*MAX_LEN-1:0] w_cand_data;

  assign w_active     = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_start_ok   = i_start && ((r_state == S_IDLE) || (r_state == S_FOUND) || (r_state == S_EXH));
  assign w_cand_valid = (r_state == S_RUN) && (r_count < (AW+1)'(FIFO_DEPTH));
  assign w_push       = w_cand_valid && i_cand_ready;
  assign w_pop        = i_dig_valid && w_active && (r_count != '0);
  assign w_match      = w_pop && (i_dig_data == r_target);
  // A digest with nothing in flight cannot be paired; it is dropped and flagged.
  assign w_proto      = i_dig_valid && w_active && (r_count == '0);
  assign w_count_nxt  = r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
  assign w_head       = r_fifo[r_rd_ptr];

  // Bytes above the current length read as zero even though they hold CHAR_MIN.
  always_comb begin
    w_cand_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < r_len) w_cand_data[8*i +: 8] = r_chars[i];
    end
  end

  // Odometer step: add stride at char 0 in base RADIX, ripple the carry upward, and grow
  // the length when the carry leaves the top char. A carry out at MAX_LEN ends issue.
  always_comb begin : step
    logic [8:0] v_sum;
    logic       v_carry;
    w_nxt_chars = r_chars;
    w_nxt_len   = r_len;
    v_sum       = {1'b0, r_chars[0]} + 9'(r_stride);
    v_carry     = 1'b0;
    if (v_sum > {1'b0, CHAR_MAX}) begin
      w_nxt_chars[0] = 8'(v_sum - RADIX);
      v_carry        = 1'b1;
    end else begin
      w_nxt_chars[0] = v_sum[7:0];
    end
    for (int i = 1; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < r_len) begin
        if (v_carry) begin
          if (r_chars[i] == CHAR_MAX) begin
            w_nxt_chars[i] = CHAR_MIN;
          end else begin
            w_nxt_chars[i] = r_chars[i] + 8'd1;
            v_carry        = 1'b0;
          end
        end
      end else if (LEN_W'(i) == r_len) begin
        if (v_carry) begin
          w_nxt_chars[i] = CHAR_MIN;
          w_nxt_len      = r_len + LEN_W'(1);
          v_carry        = 1'b0;
        end
      end
    end
    w_ovf = v_carry;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next_state;
  end

  // A match always beats exhaustion, including on the pop that empties the FIFO.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_FOUND, S_EXH: begin
        if (i_start) w_next_state = S_RUN;
      end
      S_RUN: begin
        if (w_match)              w_next_state = S_FOUND;
        else if (w_push && w_ovf) w_next_state = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_match)                 w_next_state = S_FOUND;
        else if (w_count_nxt == '0)  w_next_state = S_EXH;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= cand_t'{dat: w_cand_data, len: r_len};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      for (int i = 0; i < MAX_LEN; i++) r_chars[i] <= '0;
      r_len       <= '0;
      r_stride    <= '0;
      r_target    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_found     <= 1'b0;
      r_exhausted <= 1'b0;
      r_found_pt  <= '0;
      r_found_len <= '0;
      r_tried     <= '0;
      r_proto_err <= 1'b0;
    end else if (w_start_ok) begin
      r_chars[0] <= i_start_char;
      for (int i = 1; i < MAX_LEN; i++) r_chars[i] <= CHAR_MIN;
      r_len       <= LEN_W'(1);
      r_stride    <= i_stride;
      r_target    <= i_target_hash;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_found     <= 1'b0;
      r_exhausted <= 1'b0;
      r_found_pt  <= '0;
      r_found_len <= '0;
      r_tried     <= '0;
      r_proto_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_chars  <= w_nxt_chars;
        r_len    <= w_nxt_len;
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop && (r_tried != '1)) r_tried <= r_tried + 32'd1;
      if (w_proto) r_proto_err <= 1'b1;
      if (w_match) begin
        // Everything still in flight is discarded; late digests are ignored in FOUND.
        r_found     <= 1'b1;
        r_found_pt  <= w_head.dat;
        r_found_len <= w_head.len;
        r_wr_ptr    <= '0;
        r_rd_ptr    <= '0;
        r_count     <= '0;
      end else begin
        if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= w_count_nxt;
      end
      if ((r_state == S_DRAIN) && (w_next_state == S_EXH)) r_exhausted <= 1'b1;
    end
  end

  assign o_cand_valid      = w_cand_valid;
  assign o_cand_data       = w_cand_data;
  assign o_cand_len        = r_len;
  assign o_busy            = w_active;
  assign o_found           = r_found;
  assign o_exhausted       = r_exhausted;
  assign o_found_plaintext = r_found_pt;
  assign o_found_len       = r_found_len;
  assign o_tried_count     = r_tried;
  assign o_proto_err       = r_proto_err;

endmodule

// File: tb/tb_md5_search_controller.sv
// Bench for md5_search_controller: a real MD5 core model with fixed latency returns digests
// in order; the expected candidate sequence comes from treating the odometer as an integer
// in base R that grows a digit when it reaches R^len.
module tb_md5_search_controller;
  localparam int ML    = 8;
  localparam int R     = 26;
  localparam int LAT   = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, cand_valid, cand_ready, dig_valid, busy, found, exhausted, perr;
  logic [2:0]   stride;
  logic [7:0]   start_char;
  logic [127:0] target, dig_data;
  logic [63:0]  cand_data, found_pt;
  logic [3:0]   cand_len, found_len;
  logic [31:0]  tried;

  logic         s_start, s_cand_valid, s_cand_ready, s_dig_valid, s_busy, s_found, s_exhausted, s_perr;
  logic [2:0]   s_stride;
  logic [7:0]   s_start_char;
  logic [127:0] s_target, s_dig_data;
  logic [15:0]  s_cand_data, s_found_pt;
  logic [1:0]   s_cand_len, s_found_len;
  logic [31:0]  s_tried;

  md5_search_controller u_dut (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(start), .i_stride(stride),
    .i_start_char(start_char), .i_target_hash(target), .o_cand_valid(cand_valid),
    .i_cand_ready(cand_ready), .o_cand_data(cand_data), .o_cand_len(cand_len),
    .i_dig_valid(dig_valid), .i_dig_data(dig_data), .o_busy(busy), .o_found(found),
    .o_exhausted(exhausted), .o_found_plaintext(found_pt), .o_found_len(found_len),
    .o_tried_count(tried), .o_proto_err(perr)
  );

  md5_search_controller #(.MAX_LEN(2), .CHAR_MAX(8'h63)) u_small (
    .i_clk(clk), .i_reset_n(reset_n), .i_start(s_start), .i_stride(s_stride),
    .i_start_char(s_start_char), .i_target_hash(s_target), .o_cand_valid(s_cand_valid),
    .i_cand_ready(s_cand_ready), .o_cand_data(s_cand_data), .o_cand_len(s_cand_len),
    .i_dig_valid(s_dig_valid), .i_dig_data(s_dig_data), .o_busy(s_busy), .o_found(s_found),
    .o_exhausted(s_exhausted), .o_found_plaintext(s_found_pt), .o_found_len(s_found_len),
    .o_tried_count(s_tried), .o_proto_err(s_perr)
  );

  typedef struct { logic [127:0] dig; int due; } core_t;
  core_t dq[$];
  core_t sq[$];
  logic [15:0] s_seen[$];

  int nvec = 0, nerr = 0, cyc = 0;
  int hs_cnt = 0, s_hs_cnt = 0, core_budget = 0;
  longint m_v;
  int m_len, m_stride;
  bit m_done;
  logic [31:0] kt [64];
  int sh_tab [16];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  // Single-block MD5 of the plaintext; the string's first byte is the slowest char (top byte).
  function automatic logic [127:0] md5(input logic [63:0] pt, input int len);
    logic [7:0]  blk [64];
    logic [31:0] m [16];
    logic [31:0] a, b, c, d, f;
    int g, s;
    for (int i = 0; i < 64; i++) blk[i] = 8'h00;
    for (int k = 0; k < len; k++) blk[k] = pt[8*(len-1-k) +: 8];
    blk[len] = 8'h80;
    blk[56]  = 8'(len * 8);
    for (int w = 0; w < 16; w++) m[w] = {blk[4*w+3], blk[4*w+2], blk[4*w+1], blk[4*w]};
    a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i;               end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5*i + 1) % 16;  end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3*i + 5) % 16;  end
      else             begin f = c ^ (b | ~d);       g = (7*i) % 16;      end
      f = f + a + kt[i] + m[g];
      a = d; d = c; c = b;
      s = sh_tab[(i/16)*4 + (i%4)];
      b = b + ((f << s) | (f >> (32 - s)));
    end
    a = a + 32'h67452301; b = b + 32'hefcdab89; c = c + 32'h98badcfe; d = d + 32'h10325476;
    return {bswap(a), bswap(b), bswap(c), bswap(d)};
  endfunction

  function automatic longint rpow(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * R;
    return p;
  endfunction

  function automatic logic [63:0] model_pt(input longint v, input int len);
    logic [63:0] p = '0;
    longint x = v;
    for (int i = 0; i < len; i++) begin
      p[8*i +: 8] = 8'(64'h61 + 64'(x % R));
      x = x / R;
    end
    return p;
  endfunction

  function automatic void model_step();
    m_v = m_v + m_stride;
    if (m_v >= rpow(m_len)) begin
      if (m_len < ML) begin
        m_v = m_v - rpow(m_len);
        m_len++;
      end else begin
        m_done = 1'b1;
      end
    end
  endfunction

  // One clock: note handshakes before the edge, score them after it, then drive digests.
  task automatic tick();
    bit hs, stall, shs;
    logic [63:0] hd;
    logic [3:0]  hl;
    logic [15:0] sd;
    logic [1:0]  sl;
    core_t e;
    hs    = (cand_valid === 1'b1) && cand_ready;
    stall = (cand_valid === 1'b1) && !cand_ready;
    hd = cand_data; hl = cand_len;
    shs = (s_cand_valid === 1'b1) && s_cand_ready;
    sd = s_cand_data; sl = s_cand_len;
    @(posedge clk); #1; cyc++;
    if (hs) begin
      hs_cnt++;
      check("cand_seq", {hl, hd}, {4'(m_len), model_pt(m_v, m_len)});
      model_step();
      e.dig = md5(hd, int'(hl)); e.due = cyc + LAT - 1;
      dq.push_back(e);
    end
    if (stall && cand_valid === 1'b1)
      check("stall_hold", {cand_len, cand_data}, {4'(m_len), model_pt(m_v, m_len)});
    if (shs) begin
      s_hs_cnt++;
      s_seen.push_back(sd);
      e.dig = md5({48'h0, sd}, int'(sl)); e.due = cyc + LAT - 1;
      sq.push_back(e);
    end
    dig_valid = 1'b0; dig_data = '0;
    if (core_budget > 0 && dq.size() > 0 && dq[0].due <= cyc) begin
      dig_valid = 1'b1; dig_data = dq[0].dig;
      void'(dq.pop_front());
      core_budget--;
    end
    s_dig_valid = 1'b0; s_dig_data = '0;
    if (sq.size() > 0 && sq[0].due <= cyc) begin
      s_dig_valid = 1'b1; s_dig_data = sq[0].dig;
      void'(sq.pop_front());
    end
  endtask

  task automatic start_main(input logic [7:0] sc, input int st, input logic [127:0] tgt);
    m_v = longint'(sc - 8'h61); m_len = 1; m_done = 1'b0; m_stride = st;
    start_char = sc; stride = 3'(st); target = tgt; start = 1'b1;
    tick();
    start = 1'b0;
    check("first_valid", cand_valid, 1);
  endtask

  task automatic do_search(input logic [7:0] sc, input int st, input logic [127:0] tgt,
                           input logic [63:0] ept, input int elen, input int etried);
    int n;
    core_budget = 1 << 30;
    start_main(sc, st, tgt);
    n = 0;
    while (!found && !exhausted && n < 3000) begin
      cand_ready = ($urandom_range(0, 3) != 0);
      tick();
      n++;
    end
    cand_ready = 1'b0;
    check("search_done", {found, exhausted, busy}, 3'b100);
    check("found_pt", found_pt, ept);
    check("found_len", found_len, elen);
    check("tried", tried, etried);
    check("proto", perr, 0);
    n = 0;
    while (dq.size() > 0 && n < 200) begin tick(); n++; end
    tick(); tick();
    check("found_sticky", {found, tried}, {1'b1, 32'(etried)});
    check("proto_after", perr, 0);
  endtask

  initial begin
    logic [7:0]  sc;
    logic [63:0] ept;
    logic [15:0] sexp;
    int st, tidx, n;
    for (int i = 0; i < 64; i++) begin
      real r;
      r = $sin(real'(i + 1));
      if (r < 0.0) r = -r;
      kt[i] = 32'(longint'($floor(r * 4294967296.0)));
    end
    sh_tab = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};
    reset_n = 1'b0; start = 1'b0; stride = '0; start_char = '0; target = '0;
    cand_ready = 1'b0; dig_valid = 1'b0; dig_data = '0;
    s_start = 1'b0; s_stride = '0; s_start_char = '0; s_target = '0;
    s_cand_ready = 1'b0; s_dig_valid = 1'b0; s_dig_data = '0;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    check("rst_flags", {cand_valid, busy, found, exhausted, perr}, 5'b0);
    check("rst_data", {cand_len, cand_data, found_len, found_pt, tried}, '0);
    check("rst_small", {s_cand_valid, s_busy, s_found, s_exhausted, s_perr, s_tried}, '0);

    // Directed searches with known MD5 targets.
    do_search(8'h61, 1, 128'h0cc175b9c0f1b6a831c399e269772661, 64'h61, 1, 1);
    do_search(8'h61, 1, 128'h187ef4436122d1cc2f40dc2b92f0eba0, 64'h6162, 2, 28);
    do_search(8'h62, 2, 128'h187ef4436122d1cc2f40dc2b92f0eba0, 64'h6162, 2, 14);

    // Random start/stride with a target picked from the arithmetic keyspace model.
    for (int t = 0; t < 4; t++) begin
      sc   = 8'(8'h61 + $urandom_range(0, 25));
      st   = $urandom_range(1, 7);
      tidx = $urandom_range(0, 40);
      m_v = longint'(sc - 8'h61); m_len = 1; m_stride = st; m_done = 1'b0;
      for (int k = 0; k < tidx; k++) model_step();
      ept = model_pt(m_v, m_len);
      do_search(sc, st, md5(ept, m_len), ept, m_len, tidx + 1);
    end

    // Small keyspace (length 2, 'a'..'c'): 12 candidates, then exhaustion.
    s_start_char = 8'h61; s_stride = 3'd1; s_target = '1; s_cand_ready = 1'b1;
    s_start = 1'b1; tick(); s_start = 1'b0;
    n = 0;
    while (!s_exhausted && !s_found && n < 200) begin tick(); n++; end
    check("small_hs", s_hs_cnt, 12);
    check("small_flags", {s_exhausted, s_found, s_busy}, 3'b100);
    check("small_tried", s_tried, 12);
    for (int k = 0; k < 12; k++) begin
      if (k < 3) sexp = 16'(8'h61 + k);
      else       sexp = {8'(8'h61 + (k - 3) / 3), 8'(8'h61 + (k - 3) % 3)};
      check("small_seq", (s_seen.size() > 0) ? s_seen.pop_front() : 16'hxxxx, sexp);
    end

    // Core stalls: FIFO fills to DEPTH, then one digest frees exactly one slot.
    core_budget = 0; cand_ready = 1'b1; hs_cnt = 0;
    start_main(8'h61, 1, '1);
    repeat (30) tick();
    check("fill_count", hs_cnt, DEPTH);
    check("full_valid", cand_valid, 0);
    core_budget = 1;
    repeat (8) tick();
    check("refill_count", hs_cnt, DEPTH + 1);
    check("refill_valid", cand_valid, 0);
    check("refill_tried", tried, 1);
    core_budget = 1 << 30;
    for (int k = 0; k < 24; k++) begin
      cand_ready = (k % 3 == 0);
      tick();
    end

    // Reset mid-search with three in flight, then a stray digest in IDLE.
    reset_n = 1'b0; cand_ready = 1'b0; tick(); reset_n = 1'b1; dq.delete();
    core_budget = 0; hs_cnt = 0;
    start_main(8'h61, 1, '1);
    cand_ready = 1'b1;
    repeat (3) tick();
    cand_ready = 1'b0;
    check("inflight3", {busy, 32'(hs_cnt)}, {1'b1, 32'd3});
    reset_n = 1'b0; tick(); dq.delete(); reset_n = 1'b1;
    check("mid_rst_flags", {cand_valid, busy, found, exhausted, perr}, 5'b0);
    check("mid_rst_data", {cand_len, cand_data, found_len, found_pt, tried}, '0);
    core_budget = 1 << 30;
    dig_valid = 1'b1; dig_data = 128'(($urandom() << 1) | 1);
    tick(); tick();
    check("idle_dig_proto", {perr, busy, tried}, '0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
